sysid_src: RTL and testbench

System-identification stimulus source and error monitor for the adaptive filter: drives the filter's sample input `xn` and desired input `d`, and consumes its error output `e`. Generates an 8-bit excitation stream (fixed pattern or LFSR), computes the desired response through a fixed 4-tap reference FIR (the "unknown system"), and flags convergence or timeout from the returned error. It replaces bench-side stimulus files in self-checking and on-board runs.

---
 rtl/sysid_pkg.sv | 11 +
 rtl/sysid_if.sv | 19 +
 rtl/sysid_src_ref_fir4.sv | 51 +++++
 rtl/sysid_src.sv | 117 +++++++++++
 tb/tb_sysid_src.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg: shared state enum, widths, excitation pattern and 10-bit saturation for sysid_src
package sysid_pkg;
    localparam int XW = 8;
    localparam int DW = 10;
    localparam int AW = 14;
    typedef enum logic [2:0] {S_IDLE, S_WARM, S_TRACK, S_CONV, S_FAIL} state_t;
    localparam logic signed [XW-1:0] PAT [8] = '{8'sd16, 8'sd32, 8'sd48, 8'sd32, 8'sd16, 8'sd0, 8'sd0, 8'sd0};
    function automatic logic signed [DW-1:0] sat10(input logic signed [AW-1:0] a);
        return a > AW'(511) ? DW'(511) : a < AW'(-512) ? DW'(-512) : a[DW-1:0];
    endfunction
endpackage

// File: rtl/sysid_if.sv
// sysid_if: stimulus/monitor bundle between sysid_src (master) and its consumer (slave)
//   en, mode : run enable and excitation select (1 = LFSR)
//   x, d     : excitation sample and desired response to the filter
//   e        : filter error returned to the monitor
//   conv, fail, conv_at, busy : run status
interface sysid_if;
    import sysid_pkg::*;
    logic en;
    logic mode;
    logic signed [XW-1:0] x;
    logic signed [DW-1:0] d;
    logic signed [DW-1:0] e;
    logic conv;
    logic fail;
    logic [15:0] conv_at;
    logic busy;
    modport master (input en, mode, e, output x, d, conv, fail, conv_at, busy);
    modport slave (output en, mode, e, input x, d, conv, fail, conv_at, busy);
endinterface

// File: rtl/sysid_src_ref_fir4.sv
// ref_fir4: 4-tap reference FIR with 3-deep delay line, arithmetic shift and 10-bit saturation
//   clk, rst : clock, async active-high reset
//   clr_i    : clear the delay line (output holds)
//   adv_i    : accept x_i as the newest sample and register its response on d_o
//   x_i      : newest sample x[n]
//   d_o      : sat10((H0 x[n] + H1 x[n-1] + H2 x[n-2] + H3 x[n-3]) >>> SH)
module ref_fir4 import sysid_pkg::*; #(
    parameter int H0 = 1,
    parameter int H1 = 2,
    parameter int H2 = 1,
    parameter int H3 = 0,
    parameter int SH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 adv_i,
    input  logic signed [XW-1:0] x_i,
    output logic signed [DW-1:0] d_o
);
    localparam logic signed [3:0] C0 = 4'(H0);
    localparam logic signed [3:0] C1 = 4'(H1);
    localparam logic signed [3:0] C2 = 4'(H2);
    localparam logic signed [3:0] C3 = 4'(H3);
    logic signed [XW-1:0] x1_q, x2_q, x3_q;
    logic signed [DW-1:0] d_q;
    logic signed [11:0] p0, p1, p2, p3;
    logic signed [AW-1:0] acc;
    assign p0 = 12'(C0) * 12'(x_i);
    assign p1 = 12'(C1) * 12'(x1_q);
    assign p2 = 12'(C2) * 12'(x2_q);
    assign p3 = 12'(C3) * 12'(x3_q);
    assign acc = 14'(p0) + 14'(p1) + 14'(p2) + 14'(p3);
    assign d_o = d_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
            d_q <= '0;
        end else if (clr_i) begin
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
        end else if (adv_i) begin
            x1_q <= x_i;
            x2_q <= x1_q;
            x3_q <= x2_q;
            d_q <= sat10(acc >>> SH);
        end
endmodule

// File: rtl/sysid_src.sv
// sysid_src: system-identification excitation source, reference response and convergence monitor
//   clk, rst : clock, async active-high reset
//   bus      : sysid_if master (en/mode/e in; x/d/conv/fail/conv_at/busy out)
module sysid_src import sysid_pkg::*; #(
    parameter int H0 = 1,
    parameter int H1 = 2,
    parameter int H2 = 1,
    parameter int H3 = 0,
    parameter int SH = 2,
    parameter int THRESH = 2,
    parameter int WIN = 16,
    parameter int MAX_SAMP = 4096,
    parameter int WARM = 6,
    parameter logic [7:0] SEED = 8'hA5
) (
    input logic clk,
    input logic rst,
    sysid_if.master bus
);
    state_t state_q, state_d;
    logic [15:0] samp_q, samp_d, run_q, run_d, conv_at_q, conv_at_d, samp_inc;
    logic [7:0] lfsr_q, lfsr_d;
    logic [2:0] idx_q, idx_d;
    logic mode_q, mode_d, conv_q, conv_d, fail_q, fail_d;
    logic signed [XW-1:0] x_q, x_d;
    logic [DW-1:0] mag;
    logic start, gen, inb;
    assign start = state_q == S_IDLE && bus.en;
    assign gen = state_q != S_IDLE && bus.en;
    // unsigned 10-bit magnitude so that -512 maps to 512
    assign mag = bus.e[DW-1] ? -bus.e : bus.e;
    assign inb = mag <= DW'(THRESH);
    assign samp_inc = samp_q == 16'hFFFF ? samp_q : samp_q + 16'd1;
    // samp_q doubles as the warm-up cycle counter while in S_WARM
    always_comb begin
        state_d = state_q;
        samp_d = samp_q;
        run_d = run_q;
        idx_d = idx_q;
        lfsr_d = lfsr_q;
        mode_d = mode_q;
        conv_d = conv_q;
        fail_d = fail_q;
        conv_at_d = conv_at_q;
        x_d = x_q;
        if (!bus.en) begin
            state_d = S_IDLE;
        end else if (state_q == S_IDLE) begin
            state_d = S_WARM;
            samp_d = '0;
            run_d = '0;
            idx_d = '0;
            lfsr_d = SEED;
            mode_d = bus.mode;
            conv_d = 1'b0;
            fail_d = 1'b0;
            conv_at_d = '0;
        end else begin
            x_d = mode_q ? {lfsr_q[7], lfsr_q[7], lfsr_q[7:2]} : PAT[idx_q];
            idx_d = idx_q + 3'd1;
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (state_q == S_WARM) begin
                samp_d = samp_q == 16'(WARM - 1) ? '0 : samp_inc;
                state_d = samp_q == 16'(WARM - 1) ? S_TRACK : S_WARM;
            end else if (state_q == S_TRACK) begin
                samp_d = samp_inc;
                run_d = inb ? run_q + 16'd1 : '0;
                // decisions use the counts already registered; convergence beats timeout
                if (run_q >= 16'(WIN)) begin
                    state_d = S_CONV;
                    conv_d = 1'b1;
                    conv_at_d = samp_inc;
                end else if (samp_q >= 16'(MAX_SAMP)) begin
                    state_d = S_FAIL;
                    fail_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            samp_q <= '0;
            run_q <= '0;
            idx_q <= '0;
            lfsr_q <= SEED;
            mode_q <= 1'b0;
            conv_q <= 1'b0;
            fail_q <= 1'b0;
            conv_at_q <= '0;
            x_q <= '0;
        end else begin
            state_q <= state_d;
            samp_q <= samp_d;
            run_q <= run_d;
            idx_q <= idx_d;
            lfsr_q <= lfsr_d;
            mode_q <= mode_d;
            conv_q <= conv_d;
            fail_q <= fail_d;
            conv_at_q <= conv_at_d;
            x_q <= x_d;
        end
    ref_fir4 #(.H0(H0), .H1(H1), .H2(H2), .H3(H3), .SH(SH)) u_fir (
        .clk(clk),
        .rst(rst),
        .clr_i(start),
        .adv_i(gen),
        .x_i(x_d),
        .d_o(bus.d)
    );
    assign bus.x = x_q;
    assign bus.conv = conv_q;
    assign bus.fail = fail_q;
    assign bus.conv_at = conv_at_q;
    assign bus.busy = state_q == S_WARM || state_q == S_TRACK;
endmodule

// File: tb/tb_sysid_src.sv
// tb_sysid_src: directed self-checking bench for sysid_src and its reference FIR
module tb_sysid_src;
    import sysid_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f_clr = 1'b0;
    logic f_adv = 1'b0;
    logic signed [7:0] f_x = '0;
    logic signed [9:0] f_d;
    int tests = 0;
    int fails = 0;
    typedef struct {
        logic signed [7:0] x;
        logic signed [9:0] d;
    } vec_t;
    vec_t tbl [16];
    sysid_if bus ();
    sysid_src #(.MAX_SAMP(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    ref_fir4 #(.H0(7), .H1(7), .H2(7), .H3(7), .SH(0)) fir7 (
        .clk(clk), .rst(rst), .clr_i(f_clr), .adv_i(f_adv), .x_i(f_x), .d_o(f_d)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int px [8] = '{16, 32, 48, 32, 16, 0, 0, 0};
        int pd [8] = '{4, 16, 32, 40, 32, 16, 4, 0};
        logic [7:0] m;
        logic signed [7:0] xs;
        int ex, ed, xp1, xp2;
        for (int i = 0; i < 16; i++) begin
            tbl[i].x = 8'(px[i % 8]);
            tbl[i].d = 10'(pd[i % 8]);
        end
        bus.en = 1'b0;
        bus.mode = 1'b0;
        bus.e = '0;
        #1;
        chk("rst_x", bus.x, 0);
        chk("rst_d", bus.d, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_conv", bus.conv, 0);
        chk("rst_fail", bus.fail, 0);
        chk("rst_conv_at", bus.conv_at, 0);
        tick(1);
        rst = 1'b0;
        bus.e = 10'sd1;
        bus.en = 1'b1;
        tick(1);
        chk("entry_busy", bus.busy, 1);
        chk("entry_x", bus.x, 0);
        for (int i = 0; i < 16; i++) begin
            tick(1);
            chk($sformatf("pat_x[%0d]", i), bus.x, tbl[i].x);
            chk($sformatf("pat_d[%0d]", i), bus.d, tbl[i].d);
        end
        tick(6);
        chk("conv_early", bus.conv, 0);
        tick(1);
        chk("conv_set", bus.conv, 1);
        chk("conv_at17", bus.conv_at, 17);
        chk("conv_busy", bus.busy, 0);
        chk("conv_nofail", bus.fail, 0);
        tick(2);
        chk("conv_runs_x", bus.x, 16);
        bus.en = 1'b0;
        tick(1);
        chk("idle_x", bus.x, 16);
        chk("idle_d", bus.d, 4);
        chk("idle_busy", bus.busy, 0);
        chk("idle_sticky", bus.conv, 1);
        tick(1);
        chk("idle_x_hold", bus.x, 16);
        bus.en = 1'b1;
        tick(1);
        chk("restart_conv_clr", bus.conv, 0);
        chk("restart_at_clr", bus.conv_at, 0);
        chk("restart_busy", bus.busy, 1);
        tick(1);
        chk("restart_x0", bus.x, 16);
        chk("restart_d0", bus.d, 4);
        tick(1);
        chk("restart_x1", bus.x, 32);
        chk("restart_d1", bus.d, 16);
        tick(14);
        bus.e = 10'sd3;
        tick(1);
        bus.e = 10'sd1;
        tick(16);
        chk("break_conv_early", bus.conv, 0);
        tick(1);
        chk("break_conv", bus.conv, 1);
        chk("break_conv_at", bus.conv_at, 28);
        bus.en = 1'b0;
        tick(1);
        bus.e = 10'sd100;
        bus.en = 1'b1;
        tick(71);
        chk("fail_early", bus.fail, 0);
        chk("fail_early_busy", bus.busy, 1);
        tick(1);
        chk("fail_set", bus.fail, 1);
        chk("fail_noconv", bus.conv, 0);
        chk("fail_busy", bus.busy, 0);
        chk("fail_at", bus.conv_at, 0);
        bus.en = 1'b0;
        tick(1);
        bus.en = 1'b1;
        tick(55);
        bus.e = -10'sd2;
        tick(16);
        chk("tie_early_conv", bus.conv, 0);
        chk("tie_early_fail", bus.fail, 0);
        tick(1);
        chk("tie_conv", bus.conv, 1);
        chk("tie_fail", bus.fail, 0);
        chk("tie_conv_at", bus.conv_at, 65);
        bus.en = 1'b0;
        tick(1);
        bus.mode = 1'b1;
        bus.e = 10'sd100;
        bus.en = 1'b1;
        tick(1);
        m = 8'hA5;
        xp1 = 0;
        xp2 = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            xs = {m[7], m[7], m[7:2]};
            ex = xs;
            ed = (ex + 2 * xp1 + xp2) >>> 2;
            chk($sformatf("lfsr_x[%0d]", i), bus.x, ex);
            chk($sformatf("lfsr_d[%0d]", i), bus.d, ed);
            chk($sformatf("lfsr_range[%0d]", i), int'(bus.x >= -8'sd32 && bus.x <= 8'sd31), 1);
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            xp2 = xp1;
            xp1 = ex;
        end
        chk("track_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_x", bus.x, 0);
        chk("arst_d", bus.d, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_fail", bus.fail, 0);
        tick(1);
        rst = 1'b0;
        bus.en = 1'b0;
        f_clr = 1'b1;
        tick(1);
        f_clr = 1'b0;
        f_adv = 1'b1;
        f_x = 8'sd10;
        tick(1);
        chk("fir7_one", f_d, 70);
        tick(1);
        chk("fir7_two", f_d, 140);
        f_x = 8'sd127;
        tick(4);
        chk("fir7_satpos", f_d, 511);
        f_x = -8'sd128;
        tick(2);
        chk("fir7_mixed", f_d, -14);
        tick(2);
        chk("fir7_satneg", f_d, -512);
        f_adv = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
